// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by write-back, decode and hazard logic.
package regfile_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;
    localparam int ZERO_REG   = 31;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
        logic [DATA_W-1:0]     data;
    } wb_pkt_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        reg_onehot      = '0;
        reg_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register, two read ports.
module reg_scoreboard #(
    parameter int NREG     = regfile_pkg::NREG,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              set_en,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] set_idx,
    input  logic                              clr_en,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] clr_idx,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] rd_a,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] rd_b,
    output logic                              busy_a,
    output logic                              busy_b
);
    import regfile_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Set is applied after clear so a new load to the register retiring in WB stays pending.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != ZERO_IDX)) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_a = busy[rd_a];
    assign busy_b = busy[rd_b];

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: MEM/WB register, register-array write port, decode bypass and load-use hazard.
module reg_writeback #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NREG     = regfile_pkg::NREG,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_valid,
    input  logic                              mem_reg_write,
    input  logic                              mem_mem_to_reg,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]                 mem_alu_result,
    input  logic [DATA_W-1:0]                 mem_load_data,
    input  logic                              stall,
    input  logic                              flush,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] id_rs1,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] id_rs2,
    input  logic                              id_issue_load,
    input  logic [regfile_pkg::REG_ADDR_W-1:0] id_load_rd,
    output logic [DATA_W-1:0]                 reg_d,
    output logic [NREG-1:0]                   reg_e,
    output logic                              fwd_a,
    output logic                              fwd_b,
    output logic                              hazard
);
    import regfile_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    wb_pkt_t wb;
    logic    busy_a;
    logic    busy_b;

    // Flush only kills the valid bit; under stall the remaining fields keep their held values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb <= '0;
        end else if (!stall) begin
            wb.valid   <= mem_valid & mem_reg_write & (mem_rd != ZERO_IDX) & ~flush;
            wb.rd      <= mem_rd;
            wb.is_load <= mem_mem_to_reg;
            wb.data    <= mem_mem_to_reg ? mem_load_data : mem_alu_result;
        end else if (flush) begin
            wb.valid <= 1'b0;
        end
    end

    assign reg_d = wb.data;
    assign reg_e = wb.valid ? (reg_onehot(wb.rd) & ~reg_onehot(ZERO_IDX)) : '0;

    assign fwd_a = wb.valid & (wb.rd == id_rs1) & (id_rs1 != ZERO_IDX);
    assign fwd_b = wb.valid & (wb.rd == id_rs2) & (id_rs2 != ZERO_IDX);

    reg_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .set_en  (id_issue_load),
        .set_idx (id_load_rd),
        .clr_en  (wb.valid & wb.is_load),
        .clr_idx (wb.rd),
        .rd_a    (id_rs1),
        .rd_b    (id_rs2),
        .busy_a  (busy_a),
        .busy_b  (busy_b)
    );

    // A load retiring this cycle is already covered by the bypass, so it does not stall decode.
    assign hazard = (busy_a & ~fwd_a) | (busy_b & ~fwd_b);

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_reg_write;
    logic        mem_mem_to_reg;
    logic [4:0]  mem_rd;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_load_data;
    logic        stall;
    logic        flush;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_issue_load;
    logic [4:0]  id_load_rd;
    logic [63:0] reg_d;
    logic [31:0] reg_e;
    logic        fwd_a;
    logic        fwd_b;
    logic        hazard;

    int compared   = 0;
    int mismatched = 0;

    reg_writeback dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .stall          (stall),
        .flush          (flush),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_issue_load  (id_issue_load),
        .id_load_rd     (id_load_rd),
        .reg_d          (reg_d),
        .reg_e          (reg_e),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .hazard         (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the MEM-stage inputs, then advance one rising edge and settle.
    task automatic applyStimulus(input logic v, input logic w, input logic m2r,
                                 input logic [4:0] rd, input logic [63:0] alu,
                                 input logic [63:0] ld);
        mem_valid      = v;
        mem_reg_write  = w;
        mem_mem_to_reg = m2r;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_load_data  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] check %s differs", tag);
        end
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        id_rs1 = '0;
        id_rs2 = '0;
        id_issue_load = 1'b0;
        id_load_rd = '0;
        mem_valid = 1'b0;
        mem_reg_write = 1'b0;
        mem_mem_to_reg = 1'b0;
        mem_rd = '0;
        mem_alu_result = '0;
        mem_load_data = '0;

        #12;
        checkOutput("rst_reg_e", 64'(reg_e), 64'h0);
        checkOutput("rst_reg_d", reg_d, 64'h0);
        checkOutput("rst_fwd_a", 64'(fwd_a), 64'h0);
        checkOutput("rst_hazard", 64'(hazard), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // ALU result write to X5 and bypass to rs1
        applyStimulus(1, 1, 0, 5'd5, 64'hDEAD_BEEF_0000_0001, 64'h0);
        checkOutput("alu_reg_e", 64'(reg_e), 64'h0000_0020);
        checkOutput("alu_reg_d", reg_d, 64'hDEAD_BEEF_0000_0001);
        id_rs1 = 5'd5;
        #1;
        checkOutput("alu_fwd_a", 64'(fwd_a), 64'h1);
        checkOutput("alu_fwd_b", 64'(fwd_b), 64'h0);
        id_rs1 = 5'd0;

        // X31 write and X31 load issue are both dropped
        id_issue_load = 1'b1;
        id_load_rd = 5'd31;
        applyStimulus(1, 1, 0, 5'd31, 64'h1111, 64'h0);
        id_issue_load = 1'b0;
        checkOutput("xzr_reg_e", 64'(reg_e), 64'h0);
        id_rs1 = 5'd31;
        id_rs2 = 5'd31;
        #1;
        checkOutput("xzr_hazard", 64'(hazard), 64'h0);
        checkOutput("xzr_fwd_a", 64'(fwd_a), 64'h0);
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;

        // Flush without stall squashes the incoming write
        flush = 1'b1;
        applyStimulus(1, 1, 0, 5'd6, 64'h66, 64'h0);
        flush = 1'b0;
        checkOutput("flush_reg_e", 64'(reg_e), 64'h0);

        // Reset mid-write with a pending load on X9
        id_issue_load = 1'b1;
        id_load_rd = 5'd9;
        applyStimulus(1, 1, 0, 5'd2, 64'h1234, 64'h0);
        id_issue_load = 1'b0;
        checkOutput("pre_rst_reg_e", 64'(reg_e), 64'h0000_0004);
        id_rs1 = 5'd9;
        #1;
        checkOutput("pre_rst_hazard", 64'(hazard), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_reg_e", 64'(reg_e), 64'h0);
        checkOutput("mid_rst_reg_d", reg_d, 64'h0);
        checkOutput("mid_rst_hazard", 64'(hazard), 64'h0);
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        checkOutput("post_rst_hazard", 64'(hazard), 64'h0);
        checkOutput("post_rst_reg_e", 64'(reg_e), 64'h0);
        id_rs1 = 5'd0;

        // Load-use hazard on X3 held until the load reaches WB
        id_issue_load = 1'b1;
        id_load_rd = 5'd3;
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        id_issue_load = 1'b0;
        id_rs2 = 5'd3;
        #1;
        checkOutput("lu_hazard_c1", 64'(hazard), 64'h1);
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        checkOutput("lu_hazard_c2", 64'(hazard), 64'h1);
        applyStimulus(1, 1, 1, 5'd3, 64'hAAAA, 64'hCAFE_F00D_1234_5678);
        checkOutput("lu_wb_reg_e", 64'(reg_e), 64'h0000_0008);
        checkOutput("lu_wb_reg_d", reg_d, 64'hCAFE_F00D_1234_5678);
        checkOutput("lu_wb_fwd_b", 64'(fwd_b), 64'h1);
        checkOutput("lu_wb_hazard", 64'(hazard), 64'h0);
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        checkOutput("lu_done_hazard", 64'(hazard), 64'h0);
        checkOutput("lu_done_fwd_b", 64'(fwd_b), 64'h0);
        id_rs2 = 5'd0;

        // Stall holds X8 write for three cycles, then flush under stall
        id_issue_load = 1'b1;
        id_load_rd = 5'd12;
        applyStimulus(1, 1, 0, 5'd8, 64'h5555, 64'h0);
        id_issue_load = 1'b0;
        checkOutput("stall_first_reg_e", 64'(reg_e), 64'h0000_0100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 5'd1, 64'h9999, 64'h0);
            checkOutput($sformatf("stall_reg_e_%0d", i), 64'(reg_e), 64'h0000_0100);
            checkOutput($sformatf("stall_reg_d_%0d", i), reg_d, 64'h5555);
        end
        id_rs1 = 5'd12;
        #1;
        checkOutput("stall_hazard", 64'(hazard), 64'h1);
        flush = 1'b1;
        id_issue_load = 1'b1;
        id_load_rd = 5'd13;
        applyStimulus(1, 1, 0, 5'd1, 64'h9999, 64'h0);
        flush = 1'b0;
        stall = 1'b0;
        id_issue_load = 1'b0;
        checkOutput("sflush_reg_e", 64'(reg_e), 64'h0);
        checkOutput("sflush_reg_d", reg_d, 64'h5555);
        checkOutput("sflush_hazard12", 64'(hazard), 64'h0);
        id_rs1 = 5'd0;
        id_rs2 = 5'd13;
        #1;
        checkOutput("sflush_hazard13", 64'(hazard), 64'h0);
        id_rs2 = 5'd0;

        // New X7 load issued while the old X7 load is in WB
        id_issue_load = 1'b1;
        id_load_rd = 5'd7;
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        id_issue_load = 1'b0;
        applyStimulus(1, 1, 1, 5'd7, 64'h0, 64'h77);
        checkOutput("x7_wb_reg_e", 64'(reg_e), 64'h0000_0080);
        id_issue_load = 1'b1;
        id_load_rd = 5'd7;
        applyStimulus(0, 0, 0, 5'd0, 64'h0, 64'h0);
        id_issue_load = 1'b0;
        id_rs1 = 5'd7;
        #1;
        checkOutput("x7_setwins_hazard", 64'(hazard), 64'h1);
        checkOutput("x7_setwins_fwd_a", 64'(fwd_a), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
